// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding, ALU, branch target,
// and an iterative shift-add multiplier that stalls upstream while it runs.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] immediate,
  input  logic [DATA_W-1:0] pc_addr,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [1:0]        alu_op,
  input  logic              RegDst,
  input  logic              AluSrc,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              Memread,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic [DATA_W-1:0] branch_target_out,
  output logic              zero_out,
  output logic              MemtoReg_out,
  output logic              RegWrite_out,
  output logic              Memread_out,
  output logic              MemWrite_out,
  output logic              Branch_out,
  output logic              Jump_out,
  output logic              stall_out
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned CTL_W = 6;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, mul_b_q, mul_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_result_q, alu_result_d, write_data_q, write_data_d;
  logic [DATA_W-1:0]   branch_target_q, branch_target_d;
  logic [REG_W-1:0]    write_reg_q, write_reg_d;
  logic                zero_q, zero_d;
  logic [CTL_W-1:0]    ctrl_q, ctrl_d;

  logic [DATA_W-1:0]   fwd_a, fwd_b, src_b, alu_res, load_res, load_wd;
  logic [5:0]          funct;
  logic                is_mult, load_en;

  assign funct   = immediate[5:0];
  assign is_mult = (alu_op == 2'b10) && (funct == 6'h18) && RegWrite;

  // EX/MEM has priority over MEM/WB; register 0 is never forwarded
  always_comb begin
    fwd_a = read_data1;
    if (ctrl_q[4] && (write_reg_q != '0) && (write_reg_q == rs_in)) fwd_a = alu_result_q;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs_in))     fwd_a = wb_data;
    fwd_b = read_data2;
    if (ctrl_q[4] && (write_reg_q != '0) && (write_reg_q == rt_in)) fwd_b = alu_result_q;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt_in))     fwd_b = wb_data;
  end

  assign src_b = AluSrc ? immediate : fwd_b;

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      2'b00: alu_res = fwd_a + src_b;
      2'b01: alu_res = fwd_a - src_b;
      2'b11: alu_res = fwd_a | src_b;
      default: begin
        unique case (funct)
          6'h20:   alu_res = fwd_a + src_b;
          6'h22:   alu_res = fwd_a - src_b;
          6'h24:   alu_res = fwd_a & src_b;
          6'h25:   alu_res = fwd_a | src_b;
          6'h2A:   alu_res = ($signed(fwd_a) < $signed(src_b)) ? DATA_W'(1) : '0;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // Multiplier sequencing and EX/MEM load; control bits default to a bubble
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_b_d  = mul_b_q;
    cnt_d    = cnt_q;
    stall_out = 1'b0;
    load_en  = 1'b0;
    load_res = alu_res;
    load_wd  = fwd_b;
    unique case (state_q)
      IDLE: begin
        if (is_mult) begin
          stall_out = 1'b1;
          mcand_d   = fwd_a;
          mplier_d  = fwd_b;
          mul_b_d   = fwd_b;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = MUL;
        end else begin
          load_en = 1'b1;
        end
      end
      MUL: begin
        stall_out = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        load_en  = 1'b1;
        load_res = acc_q;
        load_wd  = mul_b_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    alu_result_d    = alu_result_q;
    write_data_d    = write_data_q;
    write_reg_d     = write_reg_q;
    branch_target_d = branch_target_q;
    zero_d          = zero_q;
    ctrl_d          = '0;
    if (load_en) begin
      alu_result_d    = load_res;
      write_data_d    = load_wd;
      write_reg_d     = RegDst ? rd_in : rt_in;
      branch_target_d = pc_addr + (immediate << 2);
      zero_d          = (load_res == '0);
      ctrl_d          = {MemtoReg, RegWrite, Memread, MemWrite, Branch, Jump};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      mcand_q         <= '0;
      mplier_q        <= '0;
      mul_b_q         <= '0;
      cnt_q           <= '0;
      alu_result_q    <= '0;
      write_data_q    <= '0;
      write_reg_q     <= '0;
      branch_target_q <= '0;
      zero_q          <= 1'b0;
      ctrl_q          <= '0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      mul_b_q         <= mul_b_d;
      cnt_q           <= cnt_d;
      alu_result_q    <= alu_result_d;
      write_data_q    <= write_data_d;
      write_reg_q     <= write_reg_d;
      branch_target_q <= branch_target_d;
      zero_q          <= zero_d;
      ctrl_q          <= ctrl_d;
    end
  end

  assign alu_result_out    = alu_result_q;
  assign write_data_out    = write_data_q;
  assign write_reg_out     = write_reg_q;
  assign branch_target_out = branch_target_q;
  assign zero_out          = zero_q;
  assign {MemtoReg_out, RegWrite_out, Memread_out, MemWrite_out, Branch_out, Jump_out} = ctrl_q;

endmodule
